proc_sequencer: RTL and testbench
=================================

Name: proc_sequencer

Overview:
Multi-cycle control unit for Processor Z. It owns the shared instruction RAM port and arbitrates it: the external loader has the port while idle, and instruction fetch has it while running. It sequences fetch, latch, execute and writeback for each instruction, and drives the regfile read/write ports. It sits between the ram, regfile and top-level processor pins, and replaces the ad-hoc PC/read logic in the top level.

Parameters:
RAM_LATENCY, 1, cycles from the mem_rd edge to valid mem_rdata (1..4).
PC_RESET, 9'h000, PC value after reset and after leaving HALT/ERR.

Ports:
clock  in  1  system clock; all state changes on the rising edge
reset  in  1  synchronous, active-high
working  in  1  1 = run program, 0 = loader owns RAM
ext_addr  in  9  loader address
ext_wr  in  1  loader write strobe
ext_wdata  in  32  loader write data
mem_addr  out  9  to ram addr
mem_wr  out  1  to ram wr
mem_wdata  out  32  to ram wdata
mem_rd  out  1  to ram rd
mem_rdata  in  32  from ram rdata
srcA  out  4  regfile read index A (IR rA)
srcB  out  4  regfile read index B (IR rB)
valA  in  32  regfile read data A (combinational)
valB  in  32  regfile read data B (combinational)
dstE  out  4  regfile write index; 4'hF = no write
valE  out  32  regfile write data
pc  out  9  current PC
state  out  3  FSM state code
halted  out  1  halt executed
err  out  1  illegal instruction trapped

Behaviour:
- Reset: state=IDLE, pc=PC_RESET, IR=0, ZF=SF=0, dstE=4'hF, valE=0, halted=0, err=0, wait counter=0.
- State codes: IDLE=0, FETCH=1, WAIT=2, LATCH=3, EXEC=4, WB=5, HALT=6, ERR=7.
- Memory mux (combinational):
  - In IDLE: mem_addr=ext_addr, mem_wr=ext_wr, mem_wdata=ext_wdata, mem_rd=0.
  - In any other state: mem_wr=0, mem_wdata=0, mem_addr=pc. ext_* are ignored.
  - mem_rd=1 only in FETCH.
- Transitions:
  - IDLE -> FETCH when working=1.
  - FETCH -> WAIT if RAM_LATENCY>1, else -> LATCH.
  - WAIT stays RAM_LATENCY-1 cycles, then -> LATCH.
  - LATCH: IR<=mem_rdata; -> EXEC.
  - EXEC: decode IR; compute valE, flags and next PC; -> WB, HALT or ERR.
  - WB: dstE/valE are presented for exactly this one cycle, and the regfile writes on the edge that leaves WB. pc<=next PC; -> FETCH.
- Throughput: 4 cycles per instruction at RAM_LATENCY=1 (3+RAM_LATENCY in general).
- IR fields: icode=IR[31:28], ifun=IR[27:24], rA=IR[23:20], rB=IR[19:16], valC=IR[15:0]. srcA=rA and srcB=rB from IR at all times.
- Instruction set (decided in EXEC):
  - 0/0 halt: -> HALT, halted=1, pc unchanged.
  - F/x nop: no write, pc+1.
  - 1/0 irmovl: dst=rB, valE={16'h0,valC}.
  - 2/0 rrmovl: dst=rB, valE=valA.
  - 6/f OPl: dst=rB. f=0 valB+valA, f=1 valB-valA, f=2 valB&valA, f=3 valB^valA. Result is mod 2^32. ZF=(valE==0), SF=valE[31].
  - 7/f jump: no write. Taken if f=0 (always), f=1 (ZF), f=2 (!ZF), f=3 (SF). Taken -> pc=valC[8:0]; not taken -> pc+1.
- Flags change only on OPl.
- Illegal -> ERR, err=1, no write: any other icode/ifun; a used register field >7 (rB for 1/2/6, rA for 2/6).
- PC increment wraps 9'h1FF -> 9'h000.
- In non-WB states dstE=4'hF.
- working=0 in FETCH..WB: next state IDLE. The in-flight instruction is discarded with no writeback; pc and flags are retained. On resume, pc is refetched.
- working=0 in HALT/ERR: -> IDLE, pc=PC_RESET, halted=err=0, ZF=SF=0. HALT/ERR are otherwise sticky.
- reset overrides working in the same cycle.

Test Plan:
1. Load 10F00080, 10F10081 at addr 0,1 and 00000000 at 2, then raise working -> r0=0x80 after cycle 4, r1=0x81 after cycle 8, halted=1 with pc=2, mem_wr never 1 while running.
2. irmovl r2=5, irmovl r3=5, then 6123 (sub r2 from r3) -> r3=0, ZF=1; next 7100_0000 (je 0) -> pc=0.
3. OPl add with 0xFFFFFFFF + 1 -> valE=0, ZF=1, SF=0; xor 0x80000000^0 -> SF=1, ZF=0.
4. Word 0x5000_0000 at pc 3, or 10F9xxxx (rB=9) -> ERR, err=1, dstE stays F; working low -> IDLE, pc=0, err=0.
5. Drop working during EXEC of irmovl r4 -> r4 unchanged, state=IDLE next cycle, pc unchanged; ext_wr write at addr 7 passes through; re-raise -> same instruction refetched and written.
6. RAM_LATENCY=3, jmp to 0x1FF containing nop -> pc wraps to 0; each instruction takes 6 cycles; reset asserted in WAIT -> IDLE, pc=0, no write.

Source files
------------

// File: rtl/proc_sequencer.sv
// proc_sequencer: multi-cycle fetch/latch/exec/wb control and instruction RAM port arbiter for Processor Z.
// Latency 3+RAM_LATENCY cycles per instruction; no backpressure, working=0 aborts to IDLE.
module proc_sequencer #(
    parameter int         RAM_LATENCY = 1,
    parameter logic [8:0] PC_RESET    = 9'h000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        working,
    input  logic [8:0]  ext_addr,
    input  logic        ext_wr,
    input  logic [31:0] ext_wdata,
    output logic [8:0]  mem_addr,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    output logic        mem_rd,
    input  logic [31:0] mem_rdata,
    output logic [3:0]  srcA,
    output logic [3:0]  srcB,
    input  logic [31:0] valA,
    input  logic [31:0] valB,
    output logic [3:0]  dstE,
    output logic [31:0] valE,
    output logic [8:0]  pc,
    output logic [2:0]  state,
    output logic        halted,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_LATCH = 3'd3,
        S_EXEC  = 3'd4,
        S_WB    = 3'd5,
        S_HALT  = 3'd6,
        S_ERR   = 3'd7
    } state_t;

    localparam int WAIT_LAST = (RAM_LATENCY > 1) ? RAM_LATENCY - 2 : 0;

    state_t      st;
    logic [8:0]  pc_r;
    logic [8:0]  npc_r;
    logic [31:0] ir;
    logic        zf;
    logic        sf;
    logic        setf_r;
    logic        zf_n;
    logic        sf_n;
    logic [3:0]  dst_r;
    logic [31:0] val_r;
    logic        halted_r;
    logic        err_r;
    logic [1:0]  wait_cnt;

    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [15:0] valc;
    logic [8:0]  pc_inc;

    logic [3:0]  ex_dst;
    logic [31:0] ex_val;
    logic [8:0]  ex_npc;
    logic        ex_setf;
    logic        ex_zf;
    logic        ex_sf;
    logic        ex_halt;
    logic        ex_ill;
    logic [31:0] alu;
    logic        taken;

    assign icode  = ir[31:28];
    assign ifun   = ir[27:24];
    assign ra     = ir[23:20];
    assign rb     = ir[19:16];
    assign valc   = ir[15:0];
    assign pc_inc = pc_r + 9'd1;

    // The loader owns the RAM port only while idle.
    assign mem_addr  = (st == S_IDLE) ? ext_addr : pc_r;
    assign mem_wr    = (st == S_IDLE) && ext_wr;
    assign mem_wdata = (st == S_IDLE) ? ext_wdata : 32'h0;
    assign mem_rd    = (st == S_FETCH);

    assign srcA   = ra;
    assign srcB   = rb;
    assign dstE   = (working && !reset) ? dst_r : 4'hF;
    assign valE   = val_r;
    assign pc     = pc_r;
    assign state  = st;
    assign halted = halted_r;
    assign err    = err_r;

    always_comb begin
        ex_dst  = 4'hF;
        ex_val  = 32'h0;
        ex_npc  = pc_inc;
        ex_setf = 1'b0;
        ex_halt = 1'b0;
        ex_ill  = 1'b0;
        alu     = 32'h0;
        taken   = 1'b0;
        case (icode)
            4'h0: begin
                if (ifun == 4'h0) ex_halt = 1'b1;
                else              ex_ill  = 1'b1;
            end
            4'hF: ex_dst = 4'hF;
            4'h1: begin
                if (ifun == 4'h0 && !rb[3]) begin
                    ex_dst = rb;
                    ex_val = {16'h0, valc};
                end else begin
                    ex_ill = 1'b1;
                end
            end
            4'h2: begin
                if (ifun == 4'h0 && !ra[3] && !rb[3]) begin
                    ex_dst = rb;
                    ex_val = valA;
                end else begin
                    ex_ill = 1'b1;
                end
            end
            4'h6: begin
                if (ifun[3:2] == 2'b00 && !ra[3] && !rb[3]) begin
                    case (ifun[1:0])
                        2'd0:    alu = valB + valA;
                        2'd1:    alu = valB - valA;
                        2'd2:    alu = valB & valA;
                        default: alu = valB ^ valA;
                    endcase
                    ex_dst  = rb;
                    ex_val  = alu;
                    ex_setf = 1'b1;
                end else begin
                    ex_ill = 1'b1;
                end
            end
            4'h7: begin
                if (ifun[3:2] == 2'b00) begin
                    case (ifun[1:0])
                        2'd0:    taken = 1'b1;
                        2'd1:    taken = zf;
                        2'd2:    taken = !zf;
                        default: taken = sf;
                    endcase
                    if (taken) ex_npc = valc[8:0];
                end else begin
                    ex_ill = 1'b1;
                end
            end
            default: ex_ill = 1'b1;
        endcase
        ex_zf = (alu == 32'h0);
        ex_sf = alu[31];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            st       <= S_IDLE;
            pc_r     <= PC_RESET;
            npc_r    <= PC_RESET;
            ir       <= 32'h0;
            zf       <= 1'b0;
            sf       <= 1'b0;
            setf_r   <= 1'b0;
            zf_n     <= 1'b0;
            sf_n     <= 1'b0;
            dst_r    <= 4'hF;
            val_r    <= 32'h0;
            halted_r <= 1'b0;
            err_r    <= 1'b0;
            wait_cnt <= 2'd0;
        end else begin
            case (st)
                S_IDLE: begin
                    dst_r <= 4'hF;
                    if (working) st <= S_FETCH;
                end
                S_FETCH: begin
                    wait_cnt <= 2'd0;
                    if (!working)             st <= S_IDLE;
                    else if (RAM_LATENCY > 1) st <= S_WAIT;
                    else                      st <= S_LATCH;
                end
                S_WAIT: begin
                    if (!working)                       st <= S_IDLE;
                    else if (wait_cnt == 2'(WAIT_LAST)) st <= S_LATCH;
                    else                                wait_cnt <= wait_cnt + 2'd1;
                end
                S_LATCH: begin
                    if (!working) begin
                        st <= S_IDLE;
                    end else begin
                        ir <= mem_rdata;
                        st <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (!working) begin
                        st <= S_IDLE;
                    end else if (ex_halt) begin
                        st       <= S_HALT;
                        halted_r <= 1'b1;
                    end else if (ex_ill) begin
                        st    <= S_ERR;
                        err_r <= 1'b1;
                    end else begin
                        dst_r  <= ex_dst;
                        val_r  <= ex_val;
                        npc_r  <= ex_npc;
                        setf_r <= ex_setf;
                        zf_n   <= ex_zf;
                        sf_n   <= ex_sf;
                        st     <= S_WB;
                    end
                end
                S_WB: begin
                    // Flags and PC commit together with the regfile write, so an abort leaves both untouched.
                    dst_r <= 4'hF;
                    if (!working) begin
                        st <= S_IDLE;
                    end else begin
                        pc_r <= npc_r;
                        if (setf_r) begin
                            zf <= zf_n;
                            sf <= sf_n;
                        end
                        st <= S_FETCH;
                    end
                end
                default: begin
                    if (!working) begin
                        st       <= S_IDLE;
                        pc_r     <= PC_RESET;
                        halted_r <= 1'b0;
                        err_r    <= 1'b0;
                        zf       <= 1'b0;
                        sf       <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_proc_sequencer.sv
// Bench for proc_sequencer: two instances (RAM_LATENCY 1 and 3) against an ISA-level model.
module tb_proc_sequencer;

    logic              clock;
    logic [1:0]        rst;
    logic [1:0]        working;
    logic [1:0][8:0]   ea;
    logic [1:0]        ew;
    logic [1:0][31:0]  ed;
    logic [1:0][8:0]   maddr;
    logic [1:0]        mwr;
    logic [1:0][31:0]  mwd;
    logic [1:0]        mrd;
    logic [1:0][31:0]  mrdata;
    logic [1:0][3:0]   sa;
    logic [1:0][3:0]   sb;
    logic [1:0][31:0]  va;
    logic [1:0][31:0]  vb;
    logic [1:0][3:0]   dste;
    logic [1:0][31:0]  vale;
    logic [1:0][8:0]   pco;
    logic [1:0][2:0]   sto;
    logic [1:0]        hlt;
    logic [1:0]        erro;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;

    proc_sequencer #(.RAM_LATENCY(1), .PC_RESET(9'h000)) u0 (
        .clock(clock), .reset(rst[0]), .working(working[0]),
        .ext_addr(ea[0]), .ext_wr(ew[0]), .ext_wdata(ed[0]),
        .mem_addr(maddr[0]), .mem_wr(mwr[0]), .mem_wdata(mwd[0]), .mem_rd(mrd[0]),
        .mem_rdata(mrdata[0]), .srcA(sa[0]), .srcB(sb[0]), .valA(va[0]), .valB(vb[0]),
        .dstE(dste[0]), .valE(vale[0]), .pc(pco[0]), .state(sto[0]),
        .halted(hlt[0]), .err(erro[0]));

    proc_sequencer #(.RAM_LATENCY(3), .PC_RESET(9'h000)) u1 (
        .clock(clock), .reset(rst[1]), .working(working[1]),
        .ext_addr(ea[1]), .ext_wr(ew[1]), .ext_wdata(ed[1]),
        .mem_addr(maddr[1]), .mem_wr(mwr[1]), .mem_wdata(mwd[1]), .mem_rd(mrd[1]),
        .mem_rdata(mrdata[1]), .srcA(sa[1]), .srcB(sb[1]), .valA(va[1]), .valB(vb[1]),
        .dstE(dste[1]), .valE(vale[1]), .pc(pco[1]), .state(sto[1]),
        .halted(hlt[1]), .err(erro[1]));

    // RAM and regfile surrounding each instance
    logic [31:0] ram   [2][512];
    logic [31:0] rpipe [2][3];
    logic [31:0] rf    [2][16];

    assign mrdata[0] = rpipe[0][0];
    assign mrdata[1] = rpipe[1][2];
    assign va[0] = rf[0][sa[0]];
    assign vb[0] = rf[0][sb[0]];
    assign va[1] = rf[1][sa[1]];
    assign vb[1] = rf[1][sb[1]];

    always @(posedge clock) begin
        for (int k = 0; k < 2; k++) begin
            if (mwr[k]) ram[k][maddr[k]] <= mwd[k];
            rpipe[k][0] <= mrd[k] ? ram[k][maddr[k]] : 32'hDEAD_BEEF;
            rpipe[k][1] <= rpipe[k][0];
            rpipe[k][2] <= rpipe[k][1];
            if (dste[k] != 4'hF) rf[k][dste[k]] <= vale[k];
        end
    end

    initial begin
        clock = 0;
        forever #5 clock = ~clock;
    end

    // ISA-level model: mode 0 idle, 1 running, 2 halted, 3 trapped; phase counts cycles into an instruction
    int          m_mode  [2];
    int          m_phase [2];
    logic [8:0]  m_pc    [2];
    bit          m_zf    [2];
    bit          m_sf    [2];
    logic [31:0] mr      [2][16];
    logic [3:0]  m_dst   [2];
    logic [31:0] m_val   [2];
    logic [8:0]  m_npc   [2];
    bit          m_setf  [2];
    bit          m_zfn   [2];
    bit          m_sfn   [2];

    function automatic int lat(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    task automatic model_exec(input int k);
        logic [31:0] w, a, b, r;
        logic [3:0]  ic, fn, ra, rb;
        bit          tk;
        w  = ram[k][m_pc[k]];
        ic = w[31:28]; fn = w[27:24]; ra = w[23:20]; rb = w[19:16];
        a  = mr[k][ra];
        b  = mr[k][rb];
        m_dst[k]  = 4'hF;
        m_val[k]  = 32'h0;
        m_setf[k] = 0;
        m_npc[k]  = m_pc[k] + 9'd1;
        if (ic == 0 && fn == 0) m_mode[k] = 2;
        else if (ic == 15) m_dst[k] = 4'hF;
        else if (ic == 1 && fn == 0 && rb < 8) begin
            m_dst[k] = rb; m_val[k] = {16'h0, w[15:0]};
        end else if (ic == 2 && fn == 0 && ra < 8 && rb < 8) begin
            m_dst[k] = rb; m_val[k] = a;
        end else if (ic == 6 && fn < 4 && ra < 8 && rb < 8) begin
            if (fn == 0)      r = b + a;
            else if (fn == 1) r = b - a;
            else if (fn == 2) r = b & a;
            else              r = b ^ a;
            m_dst[k] = rb; m_val[k] = r;
            m_setf[k] = 1; m_zfn[k] = (r == 0); m_sfn[k] = r[31];
        end else if (ic == 7 && fn < 4) begin
            tk = (fn == 0) || (fn == 1 && m_zf[k]) || (fn == 2 && !m_zf[k]) || (fn == 3 && m_sf[k]);
            if (tk) m_npc[k] = w[8:0];
        end else m_mode[k] = 3;
        if (m_mode[k] == 1) m_phase[k]++;
    endtask

    task automatic model_step(input int k);
        int L;
        L = lat(k);
        if (rst[k]) begin
            m_mode[k] = 0; m_phase[k] = 0; m_pc[k] = 9'h000; m_zf[k] = 0; m_sf[k] = 0;
        end else if (m_mode[k] == 0) begin
            if (working[k]) begin m_mode[k] = 1; m_phase[k] = 0; end
        end else if (m_mode[k] == 1) begin
            if (!working[k]) m_mode[k] = 0;
            else if (m_phase[k] == L + 1) model_exec(k);
            else if (m_phase[k] == L + 2) begin
                if (m_dst[k] != 4'hF) mr[k][m_dst[k]] = m_val[k];
                if (m_setf[k]) begin m_zf[k] = m_zfn[k]; m_sf[k] = m_sfn[k]; end
                m_pc[k] = m_npc[k];
                m_phase[k] = 0;
            end else m_phase[k]++;
        end else if (!working[k]) begin
            m_mode[k] = 0; m_pc[k] = 9'h000; m_zf[k] = 0; m_sf[k] = 0;
        end
    endtask

    always @(posedge clock) begin
        model_step(0);
        model_step(1);
    end

    function automatic logic [2:0] exp_state(input int k);
        if (m_mode[k] == 0) return 3'd0;
        if (m_mode[k] == 2) return 3'd6;
        if (m_mode[k] == 3) return 3'd7;
        if (m_phase[k] == 0) return 3'd1;
        if (m_phase[k] < lat(k)) return 3'd2;
        if (m_phase[k] == lat(k)) return 3'd3;
        if (m_phase[k] == lat(k) + 1) return 3'd4;
        return 3'd5;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (cmp_en) begin
            for (int k = 0; k < 2; k++) begin
                logic [3:0] xd;
                bit         idle, wb;
                idle = (m_mode[k] == 0);
                wb   = (m_mode[k] == 1) && (m_phase[k] == lat(k) + 2);
                xd   = (wb && working[k] && !rst[k]) ? m_dst[k] : 4'hF;
                chk($sformatf("state%0d", k), sto[k], exp_state(k));
                chk($sformatf("pc%0d", k), pco[k], m_pc[k]);
                chk($sformatf("mem_addr%0d", k), maddr[k], idle ? ea[k] : m_pc[k]);
                chk($sformatf("mem_wr%0d", k), mwr[k], idle ? ew[k] : 1'b0);
                chk($sformatf("mem_rd%0d", k), mrd[k], (m_mode[k] == 1 && m_phase[k] == 0));
                chk($sformatf("dstE%0d", k), dste[k], xd);
                chk($sformatf("halted%0d", k), hlt[k], m_mode[k] == 2);
                chk($sformatf("err%0d", k), erro[k], m_mode[k] == 3);
                if (xd != 4'hF) chk($sformatf("valE%0d", k), vale[k], m_val[k]);
                if (m_mode[k] == 1 && m_phase[k] == lat(k) + 1)
                    chk($sformatf("srcA%0d", k), sa[k], ram[k][m_pc[k]][23:20]);
            end
        end
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic load(input int k, input logic [8:0] a, input logic [31:0] d);
        ea[k] = a; ed[k] = d; ew[k] = 1'b1;
        tick;
        ew[k] = 1'b0;
    endtask

    task automatic run_until_stop(input int k, input int budget);
        bit done;
        done = 0;
        for (int i = 0; i < budget && !done; i++) begin
            if (sto[k] == 3'd6 || sto[k] == 3'd7) done = 1;
            else tick;
        end
        chk("stop_reached", (sto[k] == 3'd6 || sto[k] == 3'd7), 1'b1);
    endtask

    task automatic stop(input int k);
        working[k] = 1'b0;
        tick;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 512; i++) ram[k][i] = 32'h0;
            for (int i = 0; i < 16; i++) begin rf[k][i] = 32'h0; mr[k][i] = 32'h0; end
            for (int i = 0; i < 3; i++) rpipe[k][i] = 32'h0;
            m_mode[k] = 0; m_phase[k] = 0; m_pc[k] = 0; m_zf[k] = 0; m_sf[k] = 0;
            m_dst[k] = 4'hF; m_val[k] = 0; m_npc[k] = 0; m_setf[k] = 0; m_zfn[k] = 0; m_sfn[k] = 0;
        end
        rst = 2'b11; working = 2'b00; ew = 2'b00; ea = '0; ed = '0;
        tick;
        cmp_en = 1;
        tick;
        rst = 2'b00;
        chk("rst_state", sto[0], 3'd0);
        chk("rst_pc", pco[0], 9'h000);
        chk("rst_dstE", dste[0], 4'hF);
        chk("rst_valE", vale[0], 32'h0);
        chk("rst_halted_err", {hlt[0], erro[0]}, 2'b00);
        chk("rst_state1", sto[1], 3'd0);

        // Two immediates then halt
        load(0, 9'd0, 32'h10F0_0080);
        load(0, 9'd1, 32'h10F1_0081);
        load(0, 9'd2, 32'h0000_0000);
        working[0] = 1'b1;
        repeat (5) tick;
        chk("t1_r0", rf[0][0], 32'h80);
        repeat (4) tick;
        chk("t1_r1", rf[0][1], 32'h81);
        repeat (3) tick;
        chk("t1_halt_state", sto[0], 3'd6);
        chk("t1_halted", hlt[0], 1'b1);
        chk("t1_halt_pc", pco[0], 9'd2);
        stop(0);
        chk("t1_idle_pc", pco[0], 9'd0);
        chk("t1_idle_halted", hlt[0], 1'b0);

        // Subtract to zero, then je back to 0
        load(0, 9'd0, 32'h10F2_0005);
        load(0, 9'd1, 32'h10F3_0005);
        load(0, 9'd2, 32'h6123_0000);
        load(0, 9'd3, 32'h7100_0000);
        load(0, 9'd4, 32'h0000_0000);
        working[0] = 1'b1;
        repeat (17) tick;
        chk("t2_r3", rf[0][3], 32'h0);
        chk("t2_je_pc", pco[0], 9'd0);
        chk("t2_fetch", sto[0], 3'd1);
        stop(0);

        // Carry-out to zero, then build 0x80000000 and xor for SF
        load(0, 9'd0, 32'h10F1_0000);
        load(0, 9'd1, 32'h10F2_0001);
        load(0, 9'd2, 32'h6121_0000);
        load(0, 9'd3, 32'h6021_0000);
        load(0, 9'd4, 32'h7300_0028);
        load(0, 9'd5, 32'h7200_0028);
        load(0, 9'd6, 32'h10F4_8000);
        load(0, 9'd7, 32'h10F5_0000);
        for (int i = 0; i < 16; i++) load(0, 9'(8 + i), 32'h6044_0000);
        load(0, 9'h18, 32'h6354_0000);
        load(0, 9'h19, 32'h7100_0028);
        load(0, 9'h1A, 32'h7300_0030);
        load(0, 9'h28, 32'h0000_0000);
        load(0, 9'h30, 32'h0000_0000);
        working[0] = 1'b1;
        run_until_stop(0, 300);
        chk("t3_pc", pco[0], 9'h30);
        chk("t3_r1", rf[0][1], 32'h0);
        chk("t3_r4", rf[0][4], 32'h8000_0000);
        stop(0);

        // Illegal opcode and out-of-range register
        load(0, 9'd0, 32'hF000_0000);
        load(0, 9'd1, 32'hF000_0000);
        load(0, 9'd2, 32'hF000_0000);
        load(0, 9'd3, 32'h5000_0000);
        working[0] = 1'b1;
        run_until_stop(0, 40);
        chk("t4_err_state", sto[0], 3'd7);
        chk("t4_err", erro[0], 1'b1);
        chk("t4_err_pc", pco[0], 9'd3);
        chk("t4_dstE", dste[0], 4'hF);
        stop(0);
        chk("t4_idle_pc", pco[0], 9'd0);
        chk("t4_idle_err", erro[0], 1'b0);
        load(0, 9'd0, 32'h10F9_0001);
        working[0] = 1'b1;
        run_until_stop(0, 20);
        chk("t4_rb9_err", erro[0], 1'b1);
        stop(0);

        // Abort during EXEC, loader write, then refetch
        load(0, 9'd0, 32'h10F4_0077);
        load(0, 9'd1, 32'h0000_0000);
        working[0] = 1'b1;
        repeat (3) tick;
        chk("t5_exec", sto[0], 3'd4);
        working[0] = 1'b0;
        tick;
        chk("t5_idle", sto[0], 3'd0);
        chk("t5_pc_kept", pco[0], 9'd0);
        chk("t5_r4_kept", rf[0][4], 32'h8000_0000);
        load(0, 9'd7, 32'h1234_5678);
        chk("t5_ext_write", ram[0][7], 32'h1234_5678);
        working[0] = 1'b1;
        repeat (5) tick;
        chk("t5_r4", rf[0][4], 32'h77);
        chk("t5_pc", pco[0], 9'd1);
        run_until_stop(0, 20);
        stop(0);

        // Latency 3: jump to 0x1FF, wrap, reset in WAIT
        load(1, 9'd0, 32'h7000_01FF);
        load(1, 9'h1FF, 32'hF000_0000);
        working[1] = 1'b1;
        tick;
        repeat (6) tick;
        chk("t6_jmp_pc", pco[1], 9'h1FF);
        chk("t6_jmp_fetch", sto[1], 3'd1);
        repeat (6) tick;
        chk("t6_wrap_pc", pco[1], 9'h000);
        tick;
        chk("t6_wait", sto[1], 3'd2);
        rst[1] = 1'b1;
        tick;
        rst[1] = 1'b0;
        working[1] = 1'b0;
        chk("t6_rst_state", sto[1], 3'd0);
        chk("t6_rst_pc", pco[1], 9'h000);
        tick;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
